// File: rtl/regfile_sweep.sv
// regfile_sweep: parametrised multi-port register store with a registered
// read path, optional write-to-read bypass, optional hardwired zero entry
// and a multi-cycle clear sequencer with a busy/done handshake.
module regfile_sweep #(
  parameter int          DATA_W   = 16,
  parameter int          DEPTH    = 16,
  parameter int          ADDR_W   = 4,
  parameter int          N_RD     = 2,
  parameter int          BYPASS   = 0,
  parameter int          ZERO_REG = 0,
  parameter logic [2:0]  OP_CLR   = 3'b110
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [2:0]               opcode,
  input  logic [ADDR_W-1:0]        destino,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [N_RD*ADDR_W-1:0]   addr,
  output logic [N_RD*DATA_W-1:0]   data_out,
  output logic                     busy,
  output logic                     clr_done,
  output logic                     wr_drop
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        clear_ptr_q, clear_ptr_d;
  logic                     busy_q, busy_d;
  logic                     clr_done_q, clr_done_d;
  logic                     wr_drop_q, wr_drop_d;
  logic [N_RD*DATA_W-1:0]   data_out_q, data_out_d;

  logic [DATA_W-1:0]        mem [DEPTH];

  logic                     clr_req;
  logic                     zero_dest;
  logic                     wr_accept;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_waddr;
  logic [DATA_W-1:0]        mem_wdata;

  // Sequencer next state, write arbitration and handshake pulses.
  always_comb begin
    clr_req     = (opcode == OP_CLR);
    zero_dest   = (ZERO_REG != 0) && (destino == ADDR_ZERO);
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    busy_d      = 1'b0;
    clr_done_d  = 1'b0;
    wr_accept   = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = destino;
    mem_wdata   = data_in;
    case (state_q)
      ST_IDLE: begin
        wr_accept = we && !clr_req && !zero_dest;
        mem_we    = wr_accept;
        if (clr_req) begin
          state_d     = ST_CLEAR;
          clear_ptr_d = ADDR_ZERO;
          busy_d      = 1'b1;
        end else begin
          state_d     = ST_IDLE;
          clear_ptr_d = clear_ptr_q;
          busy_d      = 1'b0;
        end
      end
      ST_CLEAR: begin
        // The sweep owns the write port; user writes are dropped.
        mem_we      = 1'b1;
        mem_waddr   = clear_ptr_q;
        mem_wdata   = {DATA_W{1'b0}};
        clear_ptr_d = clear_ptr_q + PTR_ONE;
        if (clear_ptr_q == LAST_IDX) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          clr_done_d = 1'b1;
        end else begin
          state_d    = ST_CLEAR;
          busy_d     = 1'b1;
          clr_done_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_CLEAR;
        clear_ptr_d = ADDR_ZERO;
        busy_d      = 1'b1;
      end
    endcase
    // Writes to a hardwired zero entry vanish without a drop report.
    wr_drop_d = we && !zero_dest && (clr_req || (state_q == ST_CLEAR));
  end

  // Registered read ports with optional forwarding of the accepted write.
  always_comb begin
    data_out_d = {(N_RD*DATA_W){1'b0}};
    for (int k = 0; k < N_RD; k++) begin
      if ((ZERO_REG != 0) && (addr[k*ADDR_W +: ADDR_W] == ADDR_ZERO)) begin
        data_out_d[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else if ((BYPASS != 0) && mem_we && (addr[k*ADDR_W +: ADDR_W] == mem_waddr)) begin
        data_out_d[k*DATA_W +: DATA_W] = mem_wdata;
      end else begin
        data_out_d[k*DATA_W +: DATA_W] = mem[addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  // Control and output registers; reset restarts the sweep from entry 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clear_ptr_q <= ADDR_ZERO;
      busy_q      <= 1'b1;
      clr_done_q  <= 1'b0;
      wr_drop_q   <= 1'b0;
      data_out_q  <= {(N_RD*DATA_W){1'b0}};
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
      busy_q      <= busy_d;
      clr_done_q  <= clr_done_d;
      wr_drop_q   <= wr_drop_d;
      data_out_q  <= data_out_d;
    end
  end

  // Storage array; not reset, the post-reset sweep zeroes it.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign wr_drop  = wr_drop_q;

endmodule
